// File: rtl/ghr_ckpt_ring_if.sv
// Predict/resolve/commit signal bundle between the pipeline and the global-history checkpoint ring.
// The master side is the pipeline (predict stage plus EX/commit); the slave side is the ring.
interface ghr_ckpt_ring_if #(
    parameter int GH_WIDTH = 32,
    parameter int DEPTH    = 16,
    parameter int TAG_W    = 4
);
    logic                pdc_valid;
    logic                pdc_taken;
    logic                pdc_ready;
    logic [TAG_W-1:0]    pdc_tag;
    logic [GH_WIDTH-1:0] gh;
    logic                ex_valid;
    logic [TAG_W-1:0]    ex_tag;
    logic                ex_taken;
    logic                ex_mispredict;
    logic [GH_WIDTH-1:0] ex_gh;
    logic                cmt_valid;
    logic                flush;
    logic [GH_WIDTH-1:0] arch_gh;
    logic                empty;

    modport master (
        output pdc_valid, pdc_taken, ex_valid, ex_tag, ex_taken, ex_mispredict, cmt_valid, flush,
        input  pdc_ready, pdc_tag, gh, ex_gh, arch_gh, empty
    );

    modport slave (
        input  pdc_valid, pdc_taken, ex_valid, ex_tag, ex_taken, ex_mispredict, cmt_valid, flush,
        output pdc_ready, pdc_tag, gh, ex_gh, arch_gh, empty
    );
endinterface

// File: rtl/ghr_ckpt_ring.sv
// Speculative global-history register backed by a tagged checkpoint ring: each predicted
// branch saves the pre-branch history, mispredicts repair from it, and commits build arch_gh.
module ghr_ckpt_ring #(
    parameter int GH_WIDTH = 32,
    parameter int DEPTH    = 16,
    parameter int TAG_W    = 4
) (
    input  logic              clk,
    input  logic              rstn,
    ghr_ckpt_ring_if.slave    bus
);
    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    logic [GH_WIDTH-1:0] ckpt [DEPTH];
    logic                dir  [DEPTH];
    logic [DEPTH-1:0]    resolved;
    logic [TAG_W-1:0]    head;
    logic [TAG_W-1:0]    tail;
    logic [TAG_W:0]      count;
    logic [GH_WIDTH-1:0] gh;
    logic [GH_WIDTH-1:0] arch_gh;

    logic                empty;
    logic                full;
    logic                pdc_ready;
    logic                pdc_fire;
    logic                mis_fire;
    logic                cmt_fire;
    logic [TAG_W-1:0]    ex_off;
    logic [TAG_W:0]      ex_off_ext;
    logic                head_dir;
    logic [GH_WIDTH-1:0] arch_next;
    logic [TAG_W-1:0]    head_next;
    logic [TAG_W:0]      cmt_dec;

    assign empty      = (count == '0);
    assign full       = (count == FULL_COUNT);
    assign mis_fire   = bus.ex_valid & bus.ex_mispredict;
    // The front end is being redirected on flush/mispredict, so no new branch is taken then.
    assign pdc_ready  = ~full & ~bus.flush & ~mis_fire;
    assign pdc_fire   = bus.pdc_valid & pdc_ready;
    assign cmt_fire   = bus.cmt_valid & ~empty;
    assign ex_off     = bus.ex_tag - head;
    assign ex_off_ext = {1'b0, ex_off};
    assign cmt_dec    = (TAG_W+1)'(cmt_fire);

    // A mispredict on the retiring slot must commit the corrected direction, not the stale one.
    assign head_dir  = (mis_fire && (bus.ex_tag == head)) ? bus.ex_taken : dir[head];
    assign arch_next = cmt_fire ? {arch_gh[GH_WIDTH-2:0], head_dir} : arch_gh;
    assign head_next = cmt_fire ? head + TAG_W'(1) : head;

    assign bus.pdc_ready = pdc_ready;
    assign bus.pdc_tag   = tail;
    assign bus.gh        = gh;
    assign bus.ex_gh     = ckpt[bus.ex_tag];
    assign bus.arch_gh   = arch_gh;
    assign bus.empty     = empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            gh       <= '0;
            arch_gh  <= '0;
            resolved <= '0;
        end else begin
            head    <= head_next;
            arch_gh <= arch_next;
            if (pdc_fire) begin
                resolved[tail] <= 1'b0;
            end
            if (bus.ex_valid) begin
                resolved[bus.ex_tag] <= 1'b1;
            end
            if (bus.flush) begin
                gh    <= arch_next;
                tail  <= head_next;
                count <= '0;
            end else if (mis_fire) begin
                gh    <= {ckpt[bus.ex_tag][GH_WIDTH-2:0], bus.ex_taken};
                tail  <= bus.ex_tag + TAG_W'(1);
                count <= ex_off_ext + (TAG_W+1)'(1) - cmt_dec;
            end else if (pdc_fire) begin
                gh    <= {gh[GH_WIDTH-2:0], bus.pdc_taken};
                tail  <= tail + TAG_W'(1);
                count <= count + (TAG_W+1)'(1) - cmt_dec;
            end else begin
                count <= count - cmt_dec;
            end
        end
    end

    // Checkpoint payload needs no reset; only live slots are ever read back.
    always_ff @(posedge clk) begin
        if (pdc_fire) begin
            ckpt[tail] <= gh;
            dir[tail]  <= bus.pdc_taken;
        end
        if (mis_fire) begin
            dir[bus.ex_tag] <= bus.ex_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            if (bus.ex_valid) begin
                assert (ex_off_ext < count)
                    else $error("ghr_ckpt_ring: ex_tag %0d is not a live slot", bus.ex_tag);
            end
            if (cmt_fire) begin
                assert (resolved[head] || (bus.ex_valid && (bus.ex_tag == head)))
                    else $error("ghr_ckpt_ring: commit of unresolved slot %0d", head);
            end
        end
    end
endmodule

// File: tb/tb_ghr_ckpt_ring.sv
// Directed bench for ghr_ckpt_ring at GH_WIDTH=8, DEPTH=4: allocation, repair, full ring,
// pointer wrap, flush and mispredict-on-head with same-cycle commit.
module tb_ghr_ckpt_ring;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    ghr_ckpt_ring_if #(.GH_WIDTH(8), .DEPTH(4), .TAG_W(2)) bus ();

    ghr_ckpt_ring #(.GH_WIDTH(8), .DEPTH(4), .TAG_W(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.pdc_valid     = 1'b0;
        bus.pdc_taken     = 1'b0;
        bus.ex_valid      = 1'b0;
        bus.ex_tag        = '0;
        bus.ex_taken      = 1'b0;
        bus.ex_mispredict = 1'b0;
        bus.cmt_valid     = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic apply_stimulus(input logic pv, input logic pt, input logic ev, input logic [1:0] et,
                                  input logic ek, input logic em, input logic cv, input logic fl);
        bus.pdc_valid     = pv;
        bus.pdc_taken     = pt;
        bus.ex_valid      = ev;
        bus.ex_tag        = et;
        bus.ex_taken      = ek;
        bus.ex_mispredict = em;
        bus.cmt_valid     = cv;
        bus.flush         = fl;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
            else begin
                errors++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        check_output("rst_gh", 32'(bus.gh), 32'h00);
        check_output("rst_arch_gh", 32'(bus.arch_gh), 32'h00);
        check_output("rst_empty", 32'(bus.empty), 32'h1);
        check_output("rst_ready", 32'(bus.pdc_ready), 32'h1);
        check_output("rst_tag", 32'(bus.pdc_tag), 32'h0);

        $display("[TB] allocate T,N,T");
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
        check_output("alloc0_tag", 32'(bus.pdc_tag), 32'h0);
        tick();
        check_output("alloc0_gh", 32'(bus.gh), 32'h01);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
        check_output("alloc1_tag", 32'(bus.pdc_tag), 32'h1);
        tick();
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
        check_output("alloc2_tag", 32'(bus.pdc_tag), 32'h2);
        tick();
        check_output("alloc_gh", 32'(bus.gh), 32'h05);
        check_output("alloc_count", 32'(dut.count), 32'h3);
        check_output("alloc_empty", 32'(bus.empty), 32'h0);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0);
        check_output("ex_gh_tag1", 32'(bus.ex_gh), 32'h01);
        apply_stimulus(0, 0, 0, 2, 0, 0, 0, 0);
        check_output("ex_gh_tag2", 32'(bus.ex_gh), 32'h02);

        $display("[TB] mispredict tag1");
        apply_stimulus(1, 0, 1, 1, 1, 1, 0, 0);
        check_output("mis_ready_low", 32'(bus.pdc_ready), 32'h0);
        tick();
        check_output("mis_gh", 32'(bus.gh), 32'h03);
        check_output("mis_tail", 32'(bus.pdc_tag), 32'h2);
        check_output("mis_count", 32'(dut.count), 32'h2);

        $display("[TB] drain, then fill to full");
        apply_stimulus(0, 0, 1, 0, 1, 0, 1, 0);
        tick();
        check_output("drain0_arch", 32'(bus.arch_gh), 32'h01);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        check_output("drain1_arch", 32'(bus.arch_gh), 32'h03);
        check_output("drain_empty", 32'(bus.empty), 32'h1);
        check_output("drain_gh", 32'(bus.gh), 32'h03);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("fill3_ready", 32'(bus.pdc_ready), 32'h1);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("full_gh", 32'(bus.gh), 32'h3C);
        check_output("full_count", 32'(dut.count), 32'h4);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
        check_output("full_ready", 32'(bus.pdc_ready), 32'h0);
        tick();
        check_output("full_gh_hold", 32'(bus.gh), 32'h3C);
        check_output("full_count_hold", 32'(dut.count), 32'h4);
        check_output("full_tag", 32'(bus.pdc_tag), 32'h2);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
        check_output("full_ex_gh_tag0", 32'(bus.ex_gh), 32'h0F);
        apply_stimulus(0, 0, 1, 2, 1, 0, 1, 0);
        tick();
        check_output("unfull_ready", 32'(bus.pdc_ready), 32'h1);
        check_output("unfull_arch", 32'(bus.arch_gh), 32'h07);
        check_output("unfull_count", 32'(dut.count), 32'h3);

        $display("[TB] same-cycle allocate and commit with wrap");
        apply_stimulus(1, 1, 1, 3, 1, 0, 1, 0);
        tick();
        check_output("pc0_count", 32'(dut.count), 32'h3);
        check_output("pc0_head", 32'(dut.head), 32'h0);
        check_output("pc0_tail", 32'(bus.pdc_tag), 32'h3);
        check_output("pc0_gh", 32'(bus.gh), 32'h79);
        check_output("pc0_arch", 32'(bus.arch_gh), 32'h0F);
        apply_stimulus(1, 0, 1, 0, 0, 0, 1, 0);
        tick();
        check_output("pc1_count", 32'(dut.count), 32'h3);
        check_output("pc1_head", 32'(dut.head), 32'h1);
        check_output("pc1_tail", 32'(bus.pdc_tag), 32'h0);
        check_output("pc1_gh", 32'(bus.gh), 32'hF2);
        check_output("pc1_arch", 32'(bus.arch_gh), 32'h1E);

        $display("[TB] commit T,N then flush");
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_output("rst2_gh", 32'(bus.gh), 32'h00);
        check_output("rst2_empty", 32'(bus.empty), 32'h1);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("fl_pre_gh", 32'(bus.gh), 32'h0A);
        apply_stimulus(0, 0, 1, 0, 1, 0, 1, 0);
        tick();
        apply_stimulus(0, 0, 1, 1, 0, 0, 1, 0);
        tick();
        check_output("fl_pre_arch", 32'(bus.arch_gh), 32'h02);
        check_output("fl_pre_count", 32'(dut.count), 32'h2);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 1);
        check_output("fl_ready_low", 32'(bus.pdc_ready), 32'h0);
        tick();
        check_output("fl_arch", 32'(bus.arch_gh), 32'h02);
        check_output("fl_gh", 32'(bus.gh), 32'h02);
        check_output("fl_empty", 32'(bus.empty), 32'h1);
        check_output("fl_head", 32'(dut.head), 32'h2);
        check_output("fl_tail", 32'(bus.pdc_tag), 32'h2);

        $display("[TB] mispredict on head with same-cycle commit");
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("mh_pre_gh", 32'(bus.gh), 32'h0B);
        apply_stimulus(0, 0, 1, 2, 0, 1, 1, 0);
        check_output("mh_ex_gh", 32'(bus.ex_gh), 32'h02);
        tick();
        check_output("mh_gh", 32'(bus.gh), 32'h04);
        check_output("mh_arch", 32'(bus.arch_gh), 32'h04);
        check_output("mh_count", 32'(dut.count), 32'h0);
        check_output("mh_empty", 32'(bus.empty), 32'h1);
        check_output("mh_tail", 32'(bus.pdc_tag), 32'h3);
        check_output("mh_head", 32'(dut.head), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
